// File: rtl/prbs_checker.sv
// prbs_checker: PRBS-23 (x^23 + x^18 + 1) receive-side checker.
// Self-synchronises to the incoming 4-bit symbol stream, verifies alignment
// with a free-running flywheel copy of the sequence, then counts compared
// bits and bit errors for BER measurement while locked.
module prbs_checker #(
    parameter int  LOCK_BEATS   = 8,
    parameter int  LOS_THRESH   = 8,
    parameter int  LOS_WINDOW   = 16,
    parameter int  CNT_W        = 32,
    // Mirrors of the shared G-DSP engine constants
    localparam int BITS_PER_SYM = 4,
    localparam int LFSR_WIDTH   = 23,
    localparam int LFSR_TAP_A   = 23,
    localparam int LFSR_TAP_B   = 18
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [BITS_PER_SYM-1:0] bits_in,
    input  logic                    clr,
    output logic                    locked,
    output logic                    err_flag,
    output logic                    los,
    output logic [CNT_W-1:0]        bit_cnt,
    output logic [CNT_W-1:0]        err_cnt
);

    // Beats needed to completely refill the history from received bits
    localparam int FILL_BEATS = (LFSR_WIDTH + BITS_PER_SYM - 1) / BITS_PER_SYM;
    localparam int FILL_W     = $clog2(FILL_BEATS + 1);
    localparam int VER_W      = $clog2(LOCK_BEATS + 1);
    localparam int WIN_W      = $clog2(LOS_WINDOW + 1);
    localparam int ACC_W      = $clog2(LOS_THRESH + BITS_PER_SYM);
    localparam int NERR_W     = $clog2(BITS_PER_SYM + 1);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Number of set bits in a mismatch vector
    function automatic logic [NERR_W-1:0] popcount(input logic [BITS_PER_SYM-1:0] v);
        logic [NERR_W-1:0] n;
        n = '0;
        for (int i = 0; i < BITS_PER_SYM; i++) begin
            n = n + NERR_W'(v[i]);
        end
        return n;
    endfunction

    logic [1:0]              state_r;
    logic [LFSR_WIDTH-1:0]   hist_r;
    logic [FILL_W-1:0]       fill_r;
    logic [VER_W-1:0]        ver_r;
    logic [WIN_W-1:0]        win_r;
    logic [ACC_W-1:0]        acc_r;
    logic                    locked_r;
    logic                    err_flag_r;
    logic                    los_r;
    logic [CNT_W-1:0]        bit_cnt_r;
    logic [CNT_W-1:0]        err_cnt_r;

    logic [1:0]              state_s;
    logic [LFSR_WIDTH-1:0]   hist_s;
    logic [FILL_W-1:0]       fill_s;
    logic [VER_W-1:0]        ver_s;
    logic [WIN_W-1:0]        win_s;
    logic [ACC_W-1:0]        acc_s;
    logic [ACC_W-1:0]        acc_sum_s;
    logic [BITS_PER_SYM-1:0] miss_s;
    logic [NERR_W-1:0]       nerr_s;
    logic                    exp_bit_s;
    logic                    err_pulse_s;
    logic                    los_pulse_s;
    logic                    count_s;
    logic [CNT_W:0]          bit_sum_s;
    logic [CNT_W:0]          err_sum_s;
    logic [CNT_W-1:0]        bit_cnt_s;
    logic [CNT_W-1:0]        err_cnt_s;

    // Unrolled per-bit history update and comparison, oldest bit first.
    // HUNT loads received bits; VERIFY/LOCKED free-run on the predicted bit so
    // a corrupted input bit can never poison the history.
    always_comb begin
        hist_s    = hist_r;
        miss_s    = '0;
        exp_bit_s = 1'b0;
        for (int i = BITS_PER_SYM - 1; i >= 0; i--) begin
            exp_bit_s = hist_s[LFSR_TAP_A-1] ^ hist_s[LFSR_TAP_B-1];
            miss_s[i] = bits_in[i] ^ exp_bit_s;
            if (state_r == ST_HUNT) begin
                hist_s = {hist_s[LFSR_WIDTH-2:0], bits_in[i]};
            end else begin
                hist_s = {hist_s[LFSR_WIDTH-2:0], exp_bit_s};
            end
        end
    end

    // Sync state machine: fill, verify, locked with windowed loss-of-sync
    always_comb begin
        state_s     = state_r;
        fill_s      = fill_r;
        ver_s       = ver_r;
        win_s       = win_r;
        acc_s       = acc_r;
        err_pulse_s = 1'b0;
        los_pulse_s = 1'b0;
        count_s     = 1'b0;
        nerr_s      = popcount(miss_s);
        acc_sum_s   = acc_r + ACC_W'(nerr_s);
        case (state_r)
            ST_HUNT: begin
                if (fill_r == FILL_W'(FILL_BEATS - 1)) begin
                    fill_s = '0;
                    // All-zero history is the LFSR lock-up state; keep filling
                    if (hist_s != '0) begin
                        state_s = ST_VERIFY;
                        ver_s   = '0;
                    end else begin
                        state_s = ST_HUNT;
                    end
                end else begin
                    fill_s = fill_r + FILL_W'(1);
                end
            end
            ST_VERIFY: begin
                if (miss_s != '0) begin
                    state_s = ST_HUNT;
                    fill_s  = '0;
                end else if (ver_r == VER_W'(LOCK_BEATS - 1)) begin
                    state_s = ST_LOCKED;
                    win_s   = '0;
                    acc_s   = '0;
                end else begin
                    ver_s = ver_r + VER_W'(1);
                end
            end
            ST_LOCKED: begin
                count_s     = 1'b1;
                err_pulse_s = (nerr_s != '0);
                if (acc_sum_s >= ACC_W'(LOS_THRESH)) begin
                    state_s     = ST_HUNT;
                    fill_s      = '0;
                    los_pulse_s = 1'b1;
                end else if (win_r == WIN_W'(LOS_WINDOW - 1)) begin
                    win_s = '0;
                    acc_s = '0;
                end else begin
                    win_s = win_r + WIN_W'(1);
                    acc_s = acc_sum_s;
                end
            end
            default: begin
                state_s = ST_HUNT;
                fill_s  = '0;
            end
        endcase
    end

    // BER counters: clear wins, saturate at all-ones, freeze both once bit_cnt is full
    always_comb begin
        bit_cnt_s = bit_cnt_r;
        err_cnt_s = err_cnt_r;
        bit_sum_s = {1'b0, bit_cnt_r} + (CNT_W+1)'(BITS_PER_SYM);
        err_sum_s = {1'b0, err_cnt_r} + (CNT_W+1)'(nerr_s);
        if (clr) begin
            bit_cnt_s = '0;
            err_cnt_s = '0;
        end else if (valid_in && count_s && (bit_cnt_r != {CNT_W{1'b1}})) begin
            if (bit_sum_s[CNT_W]) begin
                bit_cnt_s = {CNT_W{1'b1}};
            end else begin
                bit_cnt_s = bit_sum_s[CNT_W-1:0];
            end
            if (err_sum_s[CNT_W]) begin
                err_cnt_s = {CNT_W{1'b1}};
            end else begin
                err_cnt_s = err_sum_s[CNT_W-1:0];
            end
        end else begin
            bit_cnt_s = bit_cnt_r;
            err_cnt_s = err_cnt_r;
        end
    end

    // Control state and status outputs advance only on valid beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_HUNT;
            hist_r     <= '0;
            fill_r     <= '0;
            ver_r      <= '0;
            win_r      <= '0;
            acc_r      <= '0;
            locked_r   <= 1'b0;
            err_flag_r <= 1'b0;
            los_r      <= 1'b0;
        end else if (valid_in) begin
            state_r    <= state_s;
            hist_r     <= hist_s;
            fill_r     <= fill_s;
            ver_r      <= ver_s;
            win_r      <= win_s;
            acc_r      <= acc_s;
            locked_r   <= (state_s == ST_LOCKED);
            err_flag_r <= err_pulse_s;
            los_r      <= los_pulse_s;
        end else begin
            err_flag_r <= 1'b0;
            los_r      <= 1'b0;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r <= '0;
            err_cnt_r <= '0;
        end else begin
            bit_cnt_r <= bit_cnt_s;
            err_cnt_r <= err_cnt_s;
        end
    end

    assign locked   = locked_r;
    assign err_flag = err_flag_r;
    assign los      = los_r;
    assign bit_cnt  = bit_cnt_r;
    assign err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: directed table, hand-written
// multi-cycle sequences, and randomized traffic against a queue-based model.
module tb_prbs_checker;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid_in;
    logic [3:0]       bits_in;
    logic             clr;
    logic             locked;
    logic             err_flag;
    logic             los;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] err_cnt;

    prbs_checker #(
        .LOCK_BEATS(8),
        .LOS_THRESH(8),
        .LOS_WINDOW(16),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .valid_in(valid_in),
        .bits_in(bits_in),
        .clr(clr),
        .locked(locked),
        .err_flag(err_flag),
        .los(los),
        .bit_cnt(bit_cnt),
        .err_cnt(err_cnt)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // PRBS-23 source: last 23 generated bits, oldest at index 0
    bit gq[$];

    // Reference model
    typedef enum int {M_HUNT, M_VERIFY, M_LOCKED} mstate_t;
    mstate_t ms;
    bit      mq[$];
    int      m_fill, m_clean, m_win_beats, m_win_errs;
    longint  m_bits, m_errs;
    bit      m_locked, m_errf, m_los;
    longint  MAXC = (64'd1 << CNT_W) - 1;

    typedef struct {
        bit          v;
        logic [3:0]  flip;
        bit          c;
        bit          e_lock;
        bit          e_err;
        bit          e_los;
        int unsigned e_bits;
        int unsigned e_errs;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 23; i++) mq.push_back(1'b0);
        ms = M_HUNT;
        m_fill = 0; m_clean = 0; m_win_beats = 0; m_win_errs = 0;
        m_bits = 0; m_errs = 0;
        m_locked = 0; m_errf = 0; m_los = 0;
    endtask

    task automatic model_step(input bit v, input logic [3:0] d, input bit c);
        int nerr;
        bit e, nb, anyone;
        m_errf = 0;
        m_los  = 0;
        if (v) begin
            nerr = 0;
            for (int i = 3; i >= 0; i--) begin
                e = mq[0] ^ mq[5];
                if (ms == M_HUNT) begin
                    nb = d[i];
                end else begin
                    if (d[i] != e) nerr++;
                    nb = e;
                end
                mq.push_back(nb);
                void'(mq.pop_front());
            end
            case (ms)
                M_HUNT: begin
                    m_fill++;
                    if (m_fill == 6) begin
                        m_fill = 0;
                        anyone = 0;
                        foreach (mq[j]) if (mq[j]) anyone = 1;
                        if (anyone) begin
                            ms = M_VERIFY;
                            m_clean = 0;
                        end
                    end
                end
                M_VERIFY: begin
                    if (nerr > 0) begin
                        ms = M_HUNT;
                        m_fill = 0;
                    end else begin
                        m_clean++;
                        if (m_clean == 8) begin
                            ms = M_LOCKED;
                            m_win_beats = 0;
                            m_win_errs = 0;
                        end
                    end
                end
                default: begin
                    if (m_bits < MAXC) begin
                        m_bits = (m_bits + 4 > MAXC) ? MAXC : m_bits + 4;
                        m_errs = (m_errs + nerr > MAXC) ? MAXC : m_errs + nerr;
                    end
                    m_errf = (nerr > 0);
                    m_win_errs += nerr;
                    if (m_win_errs >= 8) begin
                        ms = M_HUNT;
                        m_fill = 0;
                        m_los = 1;
                    end else begin
                        m_win_beats++;
                        if (m_win_beats == 16) begin
                            m_win_beats = 0;
                            m_win_errs = 0;
                        end
                    end
                end
            endcase
            m_locked = (ms == M_LOCKED);
        end
        if (c) begin
            m_bits = 0;
            m_errs = 0;
        end
    endtask

    // Drive one cycle with explicit data, then compare every output with the model
    task automatic beat_raw(input bit v, input logic [3:0] d, input bit c);
        valid_in = v;
        bits_in  = d;
        clr      = c;
        @(posedge clk);
        #1;
        model_step(v, d, c);
        chk("locked",   locked,   m_locked);
        chk("err_flag", err_flag, m_errf);
        chk("los",      los,      m_los);
        chk("bit_cnt",  bit_cnt,  m_bits);
        chk("err_cnt",  err_cnt,  m_errs);
    endtask

    // Drive one cycle; valid beats carry the next PRBS symbol XOR flip
    task automatic beat(input bit v, input logic [3:0] flip, input bit c);
        logic [3:0] d;
        d = 4'b0000;
        if (v) begin
            for (int i = 3; i >= 0; i--) begin
                d[i] = gq[0] ^ gq[5];
                gq.push_back(d[i]);
                void'(gq.pop_front());
            end
            d = d ^ flip;
        end else begin
            d = 4'($urandom);
        end
        beat_raw(v, d, c);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock edge
    task automatic do_reset();
        valid_in = 1'b0;
        clr      = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rst_locked",   locked,   64'd0);
        chk("rst_err_flag", err_flag, 64'd0);
        chk("rst_los",      los,      64'd0);
        chk("rst_bit_cnt",  bit_cnt,  64'd0);
        chk("rst_err_cnt",  err_cnt,  64'd0);
        #2;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic lock_up();
        for (int k = 1; k <= 14; k++) begin
            beat(1'b1, 4'b0000, 1'b0);
            if (k == 13) chk("lock_early", locked, 64'd0);
            if (k == 14) chk("lock_at14",  locked, 64'd1);
        end
    endtask

    initial begin
        int pulses, nlock, vb, guard;
        bit v;

        for (int i = 0; i < 23; i++) gq.push_back(1'b1);
        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'd4,  32'd0};
        tbl[1]  = '{1'b1, 4'b0100, 1'b0, 1'b1, 1'b1, 1'b0, 32'd8,  32'd1};
        tbl[2]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'd12, 32'd1};
        tbl[3]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'd12, 32'd1};
        tbl[4]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'd16, 32'd1};
        tbl[5]  = '{1'b1, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0,  32'd0};
        tbl[6]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'd4,  32'd0};
        tbl[7]  = '{1'b1, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 32'd8,  32'd4};
        tbl[8]  = '{1'b1, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b1, 32'd12, 32'd6};
        tbl[9]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd12, 32'd6};
        tbl[10] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0,  32'd0};

        rst_n = 1'b1; valid_in = 1'b0; bits_in = 4'b0000; clr = 1'b0;
        #1;
        do_reset();

        // Clean lock and 100 counted beats
        lock_up();
        pulses = 0;
        for (int k = 0; k < 100; k++) begin
            beat(1'b1, 4'b0000, 1'b0);
            if (err_flag) pulses++;
        end
        chk("clean_bit_cnt", bit_cnt, 64'd400);
        chk("clean_err_cnt", err_cnt, 64'd0);
        chk("clean_pulses",  pulses,  64'd0);

        // Reset in the middle of LOCKED, then relock
        do_reset();
        lock_up();

        // Directed table from a freshly cleared lock
        beat(1'b0, 4'b0000, 1'b1);
        for (int i = 0; i < 11; i++) begin
            beat(tbl[i].v, tbl[i].flip, tbl[i].c);
            chk($sformatf("tbl%0d_locked",   i), locked,   tbl[i].e_lock);
            chk($sformatf("tbl%0d_err_flag", i), err_flag, tbl[i].e_err);
            chk($sformatf("tbl%0d_los",      i), los,      tbl[i].e_los);
            chk($sformatf("tbl%0d_bit_cnt",  i), bit_cnt,  tbl[i].e_bits);
            chk($sformatf("tbl%0d_err_cnt",  i), err_cnt,  tbl[i].e_errs);
        end

        // Loss of sync: two fully inverted beats, then relock in 14
        do_reset();
        lock_up();
        beat(1'b0, 4'b0000, 1'b1);
        beat(1'b1, 4'b1111, 1'b0);
        chk("los1_locked",  locked,  64'd1);
        chk("los1_los",     los,     64'd0);
        chk("los1_err_cnt", err_cnt, 64'd4);
        beat(1'b1, 4'b1111, 1'b0);
        chk("los2_locked",  locked,  64'd0);
        chk("los2_los",     los,     64'd1);
        chk("los2_err_cnt", err_cnt, 64'd8);
        lock_up();

        // Window wrap clears the error accumulator
        beat(1'b0, 4'b0000, 1'b1);
        beat(1'b1, 4'b1111, 1'b0);
        beat(1'b1, 4'b0111, 1'b0);
        for (int k = 0; k < 14; k++) beat(1'b1, 4'b0000, 1'b0);
        beat(1'b1, 4'b1111, 1'b0);
        beat(1'b1, 4'b0111, 1'b0);
        chk("wrap_locked",  locked,  64'd1);
        chk("wrap_err_cnt", err_cnt, 64'd14);
        beat(1'b1, 4'b0001, 1'b0);
        chk("wrap_los",     los,     64'd1);

        // Error during VERIFY returns to HUNT; relock takes 14 more beats
        do_reset();
        for (int k = 0; k < 9; k++) beat(1'b1, 4'b0000, 1'b0);
        beat(1'b1, 4'b0010, 1'b0);
        chk("vfail_locked",  locked,  64'd0);
        chk("vfail_bit_cnt", bit_cnt, 64'd0);
        chk("vfail_err_cnt", err_cnt, 64'd0);
        lock_up();

        // All-zero input never locks
        do_reset();
        nlock = 0;
        for (int k = 0; k < 100; k++) begin
            beat_raw(1'b1, 4'b0000, 1'b0);
            if (locked) nlock++;
        end
        chk("zero_lock_cycles", nlock, 64'd0);

        // Random gaps: lock still after 14 valid beats, 4 bits per valid beat
        do_reset();
        vb = 0;
        guard = 0;
        while (!locked && guard < 500) begin
            v = ($urandom_range(0, 2) != 0);
            beat(v, 4'b0000, 1'b0);
            if (v) vb++;
            guard++;
        end
        chk("gap_lock_beats", vb, 64'd14);
        beat(1'b0, 4'b0000, 1'b1);
        vb = 0;
        guard = 0;
        while (vb < 25 && guard < 500) begin
            v = ($urandom_range(0, 2) != 0);
            beat(v, 4'b0000, 1'b0);
            if (v) vb++;
            guard++;
        end
        chk("gap_bit_cnt", bit_cnt, 64'd100);

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            logic [3:0] f;
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 24) == 0) ? 4'($urandom) : 4'b0000;
            beat(v, f, ($urandom_range(0, 59) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

PRBS-23 receive-side checker for the G-DSP Engine test path. It consumes the 4-bit parallel symbol stream produced by the PRBS-23 bit generator, either directly or after the QAM mapper/demapper loop. It self-synchronises to the x^23 + x^18 + 1 sequence and declares lock. Once locked, it counts compared bits and bit errors for BER measurement, and drops lock when the error density indicates loss of alignment.

## Interface
- LOCK_BEATS, 8: consecutive error-free beats in VERIFY required to enter LOCKED.
- LOS_THRESH, 8: errored bits within one LOCKED window that force loss of sync.
- LOS_WINDOW, 16: LOCKED window length in valid beats.
- CNT_W, 32: width of bit and error counters.
- BITS_PER_SYM, LFSR_WIDTH, LFSR_TAP_A/B are taken from gdsp_pkg (4, 23, 23, 18).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_in  in  1  bits_in carries a beat this cycle.
- bits_in  in  BITS_PER_SYM  received bits; bit[3] is the oldest in time, bit[0] the newest.
- clr  in  1  synchronous clear of bit_cnt and err_cnt.
- locked  out  1  high while in LOCKED.
- err_flag  out  1  one-cycle pulse: the previous beat had ≥1 error while LOCKED.
- los  out  1  one-cycle pulse on the LOCKED→HUNT transition.
- bit_cnt  out  CNT_W  bits compared while LOCKED.
- err_cnt  out  CNT_W  errored bits while LOCKED.

## Operation
- The 23-bit history register is hist. hist[0] holds the newest bit and hist[22] the oldest.
- Per bit, the expected bit is e = hist[22] ^ hist[17]. Each beat processes 4 bits serially, unrolled, starting with bits_in[3].
- **HUNT** (reset state):
  - Each received bit is shifted into hist. No comparison is made.
  - A fill counter counts valid beats. After 6 beats (24 bits), go to VERIFY if hist ≠ 0; otherwise restart the fill. The all-zero state is a lock-up state and must not verify.
- **VERIFY**:
  - hist advances with the locally generated e (flywheel), not with the received bits.
  - Each received bit is compared with e.
  - A beat with ≥1 mismatch → HUNT, and the fill counter restarts.
  - LOCK_BEATS consecutive clean beats → LOCKED.
  - Nothing is counted in this state.
- **LOCKED**:
  - The flywheel continues. Per beat, nerr = popcount of mismatches (0..4).
  - bit_cnt += 4 and err_cnt += nerr.
  - The window accumulator adds nerr. If the accumulated value (including the current beat) ≥ LOS_THRESH → HUNT, los=1, locked drops.
  - The window counter wraps at LOS_WINDOW beats and clears the accumulator at the wrap.
  - Window count and accumulator reset on entry to LOCKED.
- **Flywheel**: a single corrupted received bit produces exactly one counted error, with no self-sync error multiplication.
- **Counters**:
  - Both counters saturate at all-ones.
  - When bit_cnt would saturate, both counters freeze so the BER ratio stays valid.
  - clr zeroes both counters. If clr coincides with a valid beat, clr wins and that beat's counts are discarded. The state machine, hist and window logic still process the beat normally.
- Cycles with valid_in=0 change nothing (no state, hist or counter update). Gaps of any length are transparent.

## Timing
- All outputs are registered. Their reset values are: locked=0, err_flag=0, los=0, bit_cnt=0, err_cnt=0, state=HUNT, hist=0, all internal counters=0.
- Latency is 1 cycle. A beat accepted at edge k is reflected in all outputs after edge k.
- With continuous valid beats from reset, locked rises after the 14th beat (6 fill + 8 verify).
- err_flag and los are single-cycle pulses. Both are low on cycles without a valid beat.
- An asynchronous reset mid-operation returns to HUNT with all outputs zero, independent of clk.
- In LOCKED, the LOS check is evaluated on the same beat as counting. The triggering beat's errors are counted in err_cnt.

## Test plan
- **Reset**: assert rst_n=0 mid-LOCKED → immediately locked=0, bit_cnt=0, err_cnt=0; after release, relock takes 14 beats.
- **Clean lock**: drive from the PRBS-23 generator (seed 7FFFFF), en every cycle → locked=1 after beat 14. 100 further beats → bit_cnt=400, err_cnt=0, err_flag never pulses.
- **Single error**: while LOCKED, invert bits_in[2] on one beat → err_cnt=1, one err_flag pulse, locked stays 1, following beats are clean.
- **Loss of sync**: invert all 4 bits for 2 consecutive beats → err_cnt=8, los pulse on the 2nd beat, locked=0. With clean input afterwards, relock occurs after 14 more beats.
- **Verify failure and zero input**:
  - Corrupt one bit during the VERIFY beats → return to HUNT, counters unchanged.
  - All-zero input forever → locked never asserts.
- **Gaps and clr**:
  - Random valid_in gaps → same lock beat count and same bit_cnt per beat as the gapless case.
  - clr together with an errored beat → bit_cnt=0, err_cnt=0, locked unchanged.
